// File: rtl/param_sync_fifo.sv
// param_sync_fifo: parametrised single-clock FIFO with valid/ready handshakes
// on both sides, occupancy count, almost-full/almost-empty flags and a
// synchronous flush. rd_data is show-ahead (read straight from the head slot).
// Optional error flags (ovf, drop_cnt, err_clr) are built when the macro
// FIFO_ERR_FLAGS_EN is defined; without it, writes to a full FIFO are dropped
// silently.
module param_sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int AF_LVL = DEPTH - 1,
  parameter int AE_LVL = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [DATA_W-1:0]            wr_data,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [DATA_W-1:0]            rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full,
  output logic                         almost_empty
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                         ovf,
  output logic [7:0]                   drop_cnt,
  input  logic                         err_clr
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LVL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LVL);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("param_sync_fifo: DEPTH must be a power of 2 and >= 2");
    end
  endgenerate

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Full/empty come only from registered pointers; the extra MSB tells
  // a full ring (MSBs differ) from an empty one (pointers equal).
  always_comb begin
    w_empty = (r_wr_ptr == r_rd_ptr);
    w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
              (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    w_push  = wr_valid & ~w_full;
    w_pop   = rd_ready & ~w_empty;
  end

  assign wr_ready     = ~w_full;
  assign rd_valid     = ~w_empty;
  assign rd_data      = r_mem[r_rd_ptr[AW-1:0]];
  assign count        = r_count;
  assign almost_full  = (r_count >= AF_C);
  assign almost_empty = (r_count <= AE_C);

  // Storage write; the RAM is deliberately not reset or flushed.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // Pointer and occupancy update; flush wins over any handshake in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic       r_ovf;
  logic [7:0] r_drop_cnt;
  logic       w_drop;

  assign w_drop   = wr_valid & w_full;
  assign ovf      = r_ovf;
  assign drop_cnt = r_drop_cnt;

  // Sticky overflow and saturating drop counter; a drop coinciding with
  // err_clr is counted as the first event after the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end else if (flush) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end else if (err_clr) begin
      r_ovf      <= w_drop;
      r_drop_cnt <= w_drop ? 8'd1 : 8'd0;
    end else if (w_drop) begin
      r_ovf      <= 1'b1;
      r_drop_cnt <= (r_drop_cnt != 8'hFF) ? r_drop_cnt + 8'd1 : r_drop_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo (DATA_W=32, DEPTH=8, AF_LVL=7, AE_LVL=1).
// Accepted writes go into a queue; the head of the queue must match rd_data
// whenever the FIFO holds data, and pops remove it.
module tb_param_sync_fifo;

  localparam int DW = 32;
  localparam int DP = 8;

  logic          clk      = 1'b0;
  logic          reset    = 1'b0;
  logic          flush    = 1'b0;
  logic          wr_valid = 1'b0;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] wr_data  = '0;
  logic          wr_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [3:0]    count;
  logic          almost_full;
  logic          almost_empty;
`ifdef FIFO_ERR_FLAGS_EN
  logic          err_clr = 1'b0;
  logic          ovf;
  logic [7:0]    drop_cnt;
  logic          m_ovf;
  int            m_drop;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] q[$];

  param_sync_fifo #(.DATA_W(DW), .DEPTH(DP), .AF_LVL(7), .AE_LVL(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .ovf          (ovf),
    .drop_cnt     (drop_cnt),
    .err_clr      (err_clr)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare every visible output against the model state.
  task automatic check_state();
    int n;
    n = q.size();
    check("count", 32'(count), 32'(n));
    check("wr_ready", 32'(wr_ready), 32'(n < DP));
    check("rd_valid", 32'(rd_valid), 32'(n != 0));
    check("almost_full", 32'(almost_full), 32'(n >= 7));
    check("almost_empty", 32'(almost_empty), 32'(n <= 1));
    if (n != 0) check("rd_data", rd_data, q[0]);
`ifdef FIFO_ERR_FLAGS_EN
    check("ovf", 32'(ovf), 32'(m_ovf));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
  endtask

  // One clock: drive at the falling edge, check, then advance the model to
  // what the DUT must hold after the next rising edge.
  task automatic cycle(input logic wv, input logic [DW-1:0] wd, input logic rr, input logic fl);
    int   n;
    logic do_push;
    logic do_pop;
    @(negedge clk);
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    flush    = fl;
    #1;
    check_state();
    n       = q.size();
    do_push = wv && (n < DP);
    do_pop  = rr && (n > 0);
    if (fl) begin
      q.delete();
    end else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(wd);
    end
`ifdef FIFO_ERR_FLAGS_EN
    if (fl) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end else if (err_clr) begin
      m_ovf  = wv && (n == DP);
      m_drop = (wv && (n == DP)) ? 1 : 0;
    end else if (wv && (n == DP)) begin
      m_ovf = 1'b1;
      if (m_drop < 255) m_drop++;
    end
`endif
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    q.delete();
`ifdef FIFO_ERR_FLAGS_EN
    m_ovf  = 1'b0;
    m_drop = 0;
`endif
  endtask

  initial begin
    model_reset();
    #12;
    check_state();
    @(negedge clk);
    reset = 1'b1;

    // Empty FIFO: single write becomes visible right after its edge.
    cycle(1'b1, 32'hA5, 1'b0, 1'b0);
    idle();
    cycle(1'b0, '0, 1'b1, 1'b0);
    idle();

    // Fill to full, flags tracked each cycle.
    for (int i = 0; i < DP; i++) cycle(1'b1, 32'h11 * (i + 1), 1'b0, 1'b0);
    idle();

    // Write while full is dropped.
    cycle(1'b1, 32'hDEAD, 1'b0, 1'b0);
    idle();
`ifdef FIFO_ERR_FLAGS_EN
    err_clr = 1'b1;
    cycle(1'b1, 32'hBEEF, 1'b0, 1'b0);
    err_clr = 1'b0;
    idle();
`endif

    // Drain in order.
    for (int i = 0; i < DP; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    idle();

    // Simultaneous push/pop at count=4 across pointer wrap.
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h100 + i, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 32'h200 + i, 1'b1, 1'b0);
    idle();
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    idle();

    // Flush at count=5 overrides coincident push and pop.
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h400 + i, 1'b0, 1'b0);
    cycle(1'b1, 32'h77, 1'b1, 1'b1);
    cycle(1'b1, 32'h5A, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    idle();

    // Asynchronous reset in the middle of a write burst.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h300 + i, 1'b0, 1'b0);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data  = 32'h3FF;
    rd_ready = 1'b0;
    flush    = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_state();
    @(posedge clk);
    #1;
    check_state();
    @(negedge clk);
    reset    = 1'b1;
    wr_valid = 1'b0;
    cycle(1'b1, 32'hC3, 1'b0, 1'b0);
    idle();
    cycle(1'b0, '0, 1'b1, 1'b0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
